router_dest_reader: RTL and testbench

- Destination-side consumer for one router output port; drains the per-port output FIFO.
- Reads one packet at a time: header byte, then payload bytes, then parity byte.
- Splits the packet into header fields and a payload stream, and checks parity.
- Sits between a router output FIFO and the destination/testbench sink. Starts reading after a programmable delay so that the router's 30-cycle soft-reset timeout can be exercised.

---
 rtl/router_dest_reader_if.sv | 33 +++
 rtl/router_dest_reader.sv | 191 +++++++++++++++++++
 tb/tb_router_dest_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_dest_reader_if.sv
// ---------------------------------------------------------------------------
// router_dest_reader_if
//
// Read-side handshake between a router output FIFO and the destination
// reader that drains it.
//
// Signals:
//   vld_out   FIFO -> reader  FIFO not-empty
//   data_in   FIFO -> reader  read data, valid one cycle after an accepted read
//   read_enb  reader -> FIFO  read request (a read is accepted when
//                             read_enb & vld_out)
//
// Modports:
//   master  the FIFO side   (drives vld_out/data_in, observes read_enb)
//   slave   the reader side (observes vld_out/data_in, drives read_enb)
// ---------------------------------------------------------------------------
interface router_dest_reader_if;
  logic       vld_out;
  logic [7:0] data_in;
  logic       read_enb;

  modport master (
    output vld_out,
    output data_in,
    input  read_enb
  );

  modport slave (
    input  vld_out,
    input  data_in,
    output read_enb
  );
endinterface : router_dest_reader_if

// File: rtl/router_dest_reader.sv
// ---------------------------------------------------------------------------
// router_dest_reader
//
// Destination-side consumer for one router output port. Drains the port's
// output FIFO one packet at a time (header, payload bytes, parity byte),
// splits the header into address/length fields, streams the payload out and
// checks the XOR parity. A programmable start delay lets the router's
// soft-reset timeout be exercised by holding data in the FIFO.
//
// Parameters:
//   START_DLY  cycles counted in WAIT before the header read (0..31)
//   CNT_W      width of the completed-packet counter
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   enable      allows a new packet to start (sampled in IDLE only)
//   fifo        FIFO read handshake (slave modport of router_dest_reader_if)
//   pyld_data   payload byte, qualified by pyld_valid
//   pyld_valid  one-cycle strobe per payload byte
//   hdr_addr    header[1:0] of the most recent header
//   hdr_len     header[7:2] (payload length) of the most recent header
//   pkt_done    one-cycle pulse when the parity byte arrives
//   parity_err  parity result, valid with pkt_done, held until the next one
//   pkt_count   number of completed packets, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module router_dest_reader #(
  parameter int unsigned START_DLY = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  router_dest_reader_if.slave  fifo,
  output logic [7:0]           pyld_data,
  output logic                 pyld_valid,
  output logic [1:0]           hdr_addr,
  output logic [5:0]           hdr_len,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     pkt_count
);

  // Last value of the WAIT counter before the header read is issued.
  localparam logic [4:0] DLY_LAST = 5'(START_DLY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_HDR_RD   = 3'd2,
    S_HDR_WAIT = 3'd3,
    S_BODY     = 3'd4
  } state_t;

  state_t           state_q;
  logic [4:0]       dly_q;
  // rem_issue_q: reads still to be issued for this packet (payload + parity).
  // rem_rx_q:    bytes still to be received; 1 means the next byte is parity.
  logic [6:0]       rem_issue_q;
  logic [6:0]       rem_rx_q;
  logic [7:0]       acc_val_q;
  logic             rx_v_q;
  logic [7:0]       pyld_data_q;
  logic             pyld_valid_q;
  logic [1:0]       hdr_addr_q;
  logic [5:0]       hdr_len_q;
  logic             pkt_done_q;
  logic             parity_err_q;
  logic [CNT_W-1:0] pkt_count_q;

  logic             read_enb_c;
  logic             acc;
  logic [6:0]       rem_issue_d;
  logic [6:0]       rem_rx_d;
  logic [7:0]       acc_val_d;
  logic [6:0]       hdr_total_d;

  // read_enb is decoded straight from the state and the issue counter so
  // that it drops in the cycle the counter reaches zero; a registered
  // version would over-read the FIFO by one byte at the end of each packet.
  always_comb begin
    read_enb_c = 1'b0;
    unique case (state_q)
      S_HDR_RD: read_enb_c = 1'b1;
      S_BODY:   read_enb_c = (rem_issue_q != 7'd0);
      default:  read_enb_c = 1'b0;
    endcase
  end

  assign acc           = read_enb_c & fifo.vld_out;
  assign fifo.read_enb = read_enb_c;

  // Next-value helpers used by the FSM below.
  always_comb begin
    rem_issue_d = rem_issue_q - 7'd1;
    rem_rx_d    = rem_rx_q - 7'd1;
    acc_val_d   = acc_val_q ^ fifo.data_in;
    // Payload length plus the parity byte; 7 bits so len 63 gives 64.
    hdr_total_d = {1'b0, fifo.data_in[7:2]} + 7'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      dly_q        <= '0;
      rem_issue_q  <= '0;
      rem_rx_q     <= '0;
      acc_val_q    <= '0;
      rx_v_q       <= 1'b0;
      pyld_data_q  <= '0;
      pyld_valid_q <= 1'b0;
      hdr_addr_q   <= '0;
      hdr_len_q    <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      // data_in carries the byte of the read accepted one cycle earlier.
      rx_v_q       <= acc;
      pyld_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (enable && fifo.vld_out) begin
            state_q <= S_WAIT;
            dly_q   <= '0;
          end
        end

        S_WAIT: begin
          if (dly_q == DLY_LAST) begin
            state_q <= S_HDR_RD;
          end else begin
            dly_q <= dly_q + 5'd1;
          end
        end

        S_HDR_RD: begin
          if (acc) begin
            state_q <= S_HDR_WAIT;
          end
        end

        S_HDR_WAIT: begin
          if (rx_v_q) begin
            hdr_addr_q  <= fifo.data_in[1:0];
            hdr_len_q   <= fifo.data_in[7:2];
            acc_val_q   <= fifo.data_in;
            rem_issue_q <= hdr_total_d;
            rem_rx_q    <= hdr_total_d;
            state_q     <= S_BODY;
          end
        end

        S_BODY: begin
          if (acc) begin
            rem_issue_q <= rem_issue_d;
          end
          if (rx_v_q) begin
            rem_rx_q <= rem_rx_d;
            if (rem_rx_q == 7'd1) begin
              // Final byte of the packet is the parity byte.
              parity_err_q <= (acc_val_q != fifo.data_in);
              pkt_done_q   <= 1'b1;
              pkt_count_q  <= pkt_count_q + CNT_W'(1);
              state_q      <= S_IDLE;
            end else begin
              pyld_data_q  <= fifo.data_in;
              pyld_valid_q <= 1'b1;
              acc_val_q    <= acc_val_d;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pyld_data  = pyld_data_q;
  assign pyld_valid = pyld_valid_q;
  assign hdr_addr   = hdr_addr_q;
  assign hdr_len    = hdr_len_q;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign pkt_count  = pkt_count_q;

endmodule : router_dest_reader

// File: tb/tb_router_dest_reader.sv
// ---------------------------------------------------------------------------
// tb_router_dest_reader
//
// Directed bench for router_dest_reader. A small FIFO model (byte array plus
// read/write pointers) feeds the reader; monitors record accepted reads,
// payload strobes and pkt_done pulses. CNT_W is reduced to 3 so that the
// packet counter wrap can be reached in a handful of short packets.
// ---------------------------------------------------------------------------
module tb_router_dest_reader;
  localparam int CNT_W = 3;

  logic             clock  = 1'b0;
  logic             resetn = 1'b1;
  logic             enable = 1'b0;
  logic [7:0]       pyld_data;
  logic             pyld_valid;
  logic [1:0]       hdr_addr;
  logic [5:0]       hdr_len;
  logic             pkt_done;
  logic             parity_err;
  logic [CNT_W-1:0] pkt_count;

  router_dest_reader_if fifo_if ();

  always #5 clock = ~clock;

  router_dest_reader #(
    .START_DLY (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .fifo       (fifo_if),
    .pyld_data  (pyld_data),
    .pyld_valid (pyld_valid),
    .hdr_addr   (hdr_addr),
    .hdr_len    (hdr_len),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .pkt_count  (pkt_count)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       stall  = 1'b0;
  logic       flush  = 1'b0;

  assign fifo_if.vld_out = (wr_ptr != rd_ptr) && !stall;

  always @(posedge clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_if.read_enb && fifo_if.vld_out) begin
      fifo_if.data_in <= mem[rd_ptr];
      rd_ptr          <= rd_ptr + 1;
    end
  end

  // ---------------- monitors ----------------
  int         acc_cnt  = 0;
  int         done_cnt = 0;
  int         acc_at_done [$];
  logic [7:0] pq [$];
  logic       perr_at_done = 1'b0;

  always @(posedge clock) begin
    if (fifo_if.read_enb && fifo_if.vld_out) acc_cnt++;
  end

  always @(posedge clock) begin
    #1;
    if (pyld_valid) pq.push_back(pyld_data);
    if (pkt_done) begin
      done_cnt++;
      perr_at_done = parity_err;
      acc_at_done.push_back(acc_cnt);
    end
  end

  int total = 0;
  int bad   = 0;

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_pkt3(input logic [7:0] h, input logic [7:0] p0,
                           input logic [7:0] p1, input logic [7:0] p2,
                           input logic [7:0] par);
    push_byte(h); push_byte(p0); push_byte(p1); push_byte(p2); push_byte(par);
  endtask

  task automatic wait_done(input int target, output bit ok);
    int n = 0;
    while (done_cnt < target && n < 1000) begin
      @(negedge clock);
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic wait_acc(input int target, output bit ok);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = (acc_cnt >= target);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int b0;
    stall = 1'b0; flush = 1'b0; enable = 1'b0;
    #1 resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);
    total++; if (fifo_if.read_enb !== 1'b0) begin bad++; $display("FAIL reset_read_enb: got %b want 0", fifo_if.read_enb); end
    total++; if (pyld_valid !== 1'b0) begin bad++; $display("FAIL reset_pyld_valid: got %b want 0", pyld_valid); end
    total++; if (pyld_data !== 8'h00) begin bad++; $display("FAIL reset_pyld_data: got %h want 00", pyld_data); end
    total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    total++; if ({hdr_len, hdr_addr} !== 8'h00) begin bad++; $display("FAIL reset_hdr: got %h want 00", {hdr_len, hdr_addr}); end
    total++; if (pkt_count !== 3'd0) begin bad++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    // Preload the first packet with enable low: nothing may be read.
    b0 = acc_cnt;
    push_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    idle(6);
    total++; if (acc_cnt - b0 !== 0) begin bad++; $display("FAIL reset_enable_gate: got %0d reads want 0", acc_cnt - b0); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int b0, pb, d0, n;
    bit ok;
    b0 = acc_cnt; pb = pq.size(); d0 = done_cnt; n = 0;
    enable = 1'b1;
    // IDLE sees vld_out at the first edge, WAIT spends dly=0,1,2, so
    // read_enb is first visible after the fourth edge.
    do begin
      @(posedge clock); #1; n++;
    end while (!fifo_if.read_enb && n < 20);
    total++; if (n !== 4) begin bad++; $display("FAIL basic_start_latency: got %0d edges want 4", n); end
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(2);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (perr_at_done !== 1'b0) begin bad++; $display("FAIL basic_parity_err: got %b want 0", perr_at_done); end
    total++; if (hdr_addr !== 2'd1) begin bad++; $display("FAIL basic_hdr_addr: got %0d want 1", hdr_addr); end
    total++; if (hdr_len !== 6'd3) begin bad++; $display("FAIL basic_hdr_len: got %0d want 3", hdr_len); end
    total++; if (pkt_count !== 3'd1) begin bad++; $display("FAIL basic_pkt_count: got %0d want 1", pkt_count); end
    total++; if (acc_cnt - b0 !== 5) begin bad++; $display("FAIL basic_reads: got %0d want 5", acc_cnt - b0); end
    total++;
    if (pq.size() - pb !== 3) begin
      bad++; $display("FAIL basic_pyld_count: got %0d want 3", pq.size() - pb);
    end else if (pq[pb] !== 8'h11 || pq[pb+1] !== 8'h22 || pq[pb+2] !== 8'h33) begin
      bad++; $display("FAIL basic_pyld_data: got %h %h %h want 11 22 33", pq[pb], pq[pb+1], pq[pb+2]);
    end
    $display("test_basic done");
  endtask

  task automatic test_parity_err();
    int b0, d0;
    bit ok;
    d0 = done_cnt;
    push_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF);
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL perr_timeout: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(2);
    total++; if (perr_at_done !== 1'b1) begin bad++; $display("FAIL perr_flag_at_done: got %b want 1", perr_at_done); end
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL perr_flag_hold: got %b want 1", parity_err); end
    total++; if (pkt_count !== 3'd2) begin bad++; $display("FAIL perr_pkt_count: got %0d want 2", pkt_count); end
    // Good packet; enable is dropped after the first payload read.
    b0 = acc_cnt; d0 = done_cnt;
    push_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    wait_acc(b0 + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL perr_good_start: got %0d reads want 2", acc_cnt - b0); end
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL perr_hold_midpkt: got %b want 1", parity_err); end
    enable = 1'b0;
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL perr_enable_low_completion: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(2);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL perr_cleared: got %b want 0", parity_err); end
    total++; if (pkt_count !== 3'd3) begin bad++; $display("FAIL perr_good_pkt_count: got %0d want 3", pkt_count); end
    enable = 1'b1;
    $display("test_parity_err done");
  endtask

  task automatic test_zero_len();
    int b0, pb, d0;
    bit ok;
    b0 = acc_cnt; pb = pq.size(); d0 = done_cnt;
    push_byte(8'h02); push_byte(8'h02);
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL zlen_timeout: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(3);
    total++; if (acc_cnt - b0 !== 2) begin bad++; $display("FAIL zlen_reads: got %0d want 2", acc_cnt - b0); end
    total++; if (pq.size() - pb !== 0) begin bad++; $display("FAIL zlen_pyld_valid: got %0d strobes want 0", pq.size() - pb); end
    total++; if (perr_at_done !== 1'b0) begin bad++; $display("FAIL zlen_parity_err: got %b want 0", perr_at_done); end
    total++; if (hdr_addr !== 2'd2 || hdr_len !== 6'd0) begin bad++; $display("FAIL zlen_hdr: got addr=%0d len=%0d want addr=2 len=0", hdr_addr, hdr_len); end
    total++; if (pkt_count !== 3'd4) begin bad++; $display("FAIL zlen_pkt_count: got %0d want 4", pkt_count); end
    $display("test_zero_len done");
  endtask

  task automatic test_stall();
    int b0, pb, d0, low;
    bit ok;
    b0 = acc_cnt; pb = pq.size(); d0 = done_cnt; low = 0;
    push_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    wait_acc(b0 + 3, ok);   // header + two payload reads accepted
    total++; if (!ok) begin bad++; $display("FAIL stall_setup: got %0d reads want 3", acc_cnt - b0); end
    stall = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (fifo_if.read_enb !== 1'b1) low++;
    end
    total++; if (low !== 0) begin bad++; $display("FAIL stall_read_enb_held: got %0d low cycles want 0", low); end
    total++; if (acc_cnt - b0 !== 3) begin bad++; $display("FAIL stall_no_extra_reads: got %0d want 3", acc_cnt - b0); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL stall_early_done: got %0d want %0d", done_cnt, d0); end
    stall = 1'b0;
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(3);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (acc_cnt - b0 !== 5) begin bad++; $display("FAIL stall_reads: got %0d want 5", acc_cnt - b0); end
    total++;
    if (pq.size() - pb !== 3) begin
      bad++; $display("FAIL stall_pyld_count: got %0d want 3", pq.size() - pb);
    end else if (pq[pb] !== 8'h11 || pq[pb+1] !== 8'h22 || pq[pb+2] !== 8'h33) begin
      bad++; $display("FAIL stall_pyld_order: got %h %h %h want 11 22 33", pq[pb], pq[pb+1], pq[pb+2]);
    end
    total++; if (pkt_count !== 3'd5 || parity_err !== 1'b0) begin bad++; $display("FAIL stall_status: got cnt=%0d perr=%b want cnt=5 perr=0", pkt_count, parity_err); end
    $display("test_stall done");
  endtask

  task automatic test_async_reset();
    int b0, pb, d0;
    bit ok;
    b0 = acc_cnt; d0 = done_cnt;
    push_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    wait_acc(b0 + 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_setup: got %0d reads want 3", acc_cnt - b0); end
    #2 resetn = 1'b0;
    #1;
    // Between clock edges: only the asynchronous path can have cleared these.
    total++; if (pkt_count !== 3'd0) begin bad++; $display("FAIL areset_pkt_count: got %0d want 0", pkt_count); end
    total++; if (fifo_if.read_enb !== 1'b0) begin bad++; $display("FAIL areset_read_enb: got %b want 0", fifo_if.read_enb); end
    total++; if ({hdr_len, hdr_addr} !== 8'h00 || pyld_data !== 8'h00) begin bad++; $display("FAIL areset_outputs: got hdr=%h pyld=%h want 00 00", {hdr_len, hdr_addr}, pyld_data); end
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(5);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL areset_abandon: got %0d pulses want 0", done_cnt - d0); end
    // Fresh packet: header 0A (len 2, addr 2), parity 0A^AA^55 = F5.
    b0 = acc_cnt; pb = pq.size(); d0 = done_cnt;
    push_byte(8'h0A); push_byte(8'hAA); push_byte(8'h55); push_byte(8'hF5);
    wait_done(d0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL areset_fresh_timeout: got done=%0d want %0d", done_cnt, d0 + 1); end
    idle(3);
    total++; if (hdr_addr !== 2'd2 || hdr_len !== 6'd2) begin bad++; $display("FAIL areset_fresh_hdr: got addr=%0d len=%0d want addr=2 len=2", hdr_addr, hdr_len); end
    total++; if (pkt_count !== 3'd1 || perr_at_done !== 1'b0) begin bad++; $display("FAIL areset_fresh_status: got cnt=%0d perr=%b want cnt=1 perr=0", pkt_count, perr_at_done); end
    total++; if (acc_cnt - b0 !== 4) begin bad++; $display("FAIL areset_fresh_reads: got %0d want 4", acc_cnt - b0); end
    total++;
    if (pq.size() - pb !== 2) begin
      bad++; $display("FAIL areset_fresh_pyld_count: got %0d want 2", pq.size() - pb);
    end else if (pq[pb] !== 8'hAA || pq[pb+1] !== 8'h55) begin
      bad++; $display("FAIL areset_fresh_pyld: got %h %h want AA 55", pq[pb], pq[pb+1]);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    int b0, pb, d0, a0, wrong;
    bit ok;
    @(negedge clock); resetn = 1'b0;
    idle(2); resetn = 1'b1; idle(1);
    b0 = acc_cnt; pb = pq.size(); d0 = done_cnt; a0 = acc_at_done.size(); wrong = 0;
    // Payload 01..3F XORs to 00, so parity is FC; 40..7E XORs to 7F -> 83.
    push_byte(8'hFC);
    for (int i = 1; i <= 63; i++) push_byte(8'(i));
    push_byte(8'hFC);
    push_byte(8'hFC);
    for (int i = 64; i <= 126; i++) push_byte(8'(i));
    push_byte(8'h83);
    wait_done(d0 + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got done=%0d want %0d", done_cnt, d0 + 2); end
    idle(3);
    total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    total++; if (pkt_count !== 3'd2) begin bad++; $display("FAIL b2b_pkt_count: got %0d want 2", pkt_count); end
    total++; if (perr_at_done !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL b2b_parity_err: got %b want 0", perr_at_done); end
    total++; if (hdr_len !== 6'd63 || hdr_addr !== 2'd0) begin bad++; $display("FAIL b2b_hdr: got len=%0d addr=%0d want len=63 addr=0", hdr_len, hdr_addr); end
    total++;
    if (acc_at_done.size() - a0 !== 2) begin
      bad++; $display("FAIL b2b_done_records: got %0d want 2", acc_at_done.size() - a0);
    end else if (acc_at_done[a0] - b0 !== 65 || acc_at_done[a0+1] - b0 !== 130) begin
      bad++; $display("FAIL b2b_reads_per_pkt: got %0d,%0d want 65,130", acc_at_done[a0] - b0, acc_at_done[a0+1] - b0);
    end
    total++; if (acc_cnt - b0 !== 130) begin bad++; $display("FAIL b2b_total_reads: got %0d want 130", acc_cnt - b0); end
    total++;
    if (pq.size() - pb !== 126) begin
      bad++; $display("FAIL b2b_pyld_count: got %0d want 126", pq.size() - pb);
    end else begin
      for (int i = 0; i < 126; i++) if (pq[pb+i] !== 8'(i + 1)) wrong++;
      if (wrong !== 0) begin bad++; $display("FAIL b2b_pyld_data: got %0d wrong bytes want 0", wrong); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_wrap();
    int d0;
    bit ok;
    d0 = done_cnt;
    repeat (5) begin push_byte(8'h02); push_byte(8'h02); end
    wait_done(d0 + 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got done=%0d want %0d", done_cnt, d0 + 5); end
    idle(3);
    total++; if (pkt_count !== 3'd7) begin bad++; $display("FAIL wrap_all_ones: got %0d want 7", pkt_count); end
    push_byte(8'h02); push_byte(8'h02);
    wait_done(d0 + 6, ok);
    idle(3);
    total++; if (pkt_count !== 3'd0 || done_cnt - d0 !== 6) begin bad++; $display("FAIL wrap_to_zero: got cnt=%0d pulses=%0d want cnt=0 pulses=6", pkt_count, done_cnt - d0); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_zero_len();
    test_stall();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_router_dest_reader
